// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with a valid/ready handshake and synchronous flush.
// SKID=0 is a single register whose in_ready is combinational from out_ready.
// SKID=1 adds a second (skid) entry so in_ready comes straight from a flop,
// which breaks long combinational ready chains between pipeline stages.
//
// Handshake: a beat moves on a port when valid and ready are both high at
// the rising clock edge; valid never depends on ready, and once out_valid is
// high it stays high with stable out_data until the beat is taken (only rst
// or flush may drop it).
module pipe_skid_reg #(
   parameter int WIDTH = 32,
   parameter int SKID  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [1:0]       dbg_state
);

   // State encoding doubles as the occupancy count.
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] main_q;
   logic             in_fire;
   logic             out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign dbg_state = state_q;

   generate
      if (SKID != 0) begin : g_skid
         logic [WIDTH-1:0] skid_q;
         logic [WIDTH-1:0] main_d;
         logic [WIDTH-1:0] skid_d;
         logic [1:0]       state_d;
         logic             ready_q;

         // in_ready is a flop, so out_ready never reaches it combinationally.
         assign in_ready = ready_q;

         // Next-state and payload selection for the EMPTY/ONE/FULL machine.
         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
               EMPTY: begin
                  if (in_fire) begin
                     main_d  = in_data;
                     state_d = ONE;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     main_d = in_data;
                  end else if (in_fire) begin
                     skid_d  = in_data;
                     state_d = FULL;
                  end else if (out_fire) begin
                     state_d = EMPTY;
                  end
               end
               FULL: begin
                  // in_ready is low here, so only the drain side can move.
                  if (out_fire) begin
                     main_d  = skid_q;
                     state_d = ONE;
                  end
               end
               default: begin
                  state_d = EMPTY;
               end
            endcase
         end

         // State, payload and registered ready; rst and flush both empty the stage.
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               state_q <= EMPTY;
               main_q  <= '0;
               skid_q  <= '0;
               ready_q <= 1'b1;
            end else begin
               state_q <= state_d;
               main_q  <= main_d;
               skid_q  <= skid_d;
               ready_q <= (state_d != FULL);
            end
         end
      end else begin : g_single
         // A held beat can be replaced in the same cycle it is drained.
         assign in_ready = (state_q == EMPTY) | out_ready;

         // Single register: load on in_fire, empty on a lone out_fire.
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               state_q <= EMPTY;
               main_q  <= '0;
            end else if (in_fire) begin
               state_q <= ONE;
               main_q  <= in_data;
            end else if (out_fire) begin
               state_q <= EMPTY;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one SKID=1 and one SKID=0 instance side by side,
// directed cases followed by a random run, each checked against a FIFO
// scoreboard of accepted beats.
module tb_pipe_skid_reg;

   logic clk;
   logic rst;

   // SKID=1 instance signals
   logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
   logic [31:0] in_data1, out_data1;
   logic [1:0]  occ1, st1;

   // SKID=0 instance signals
   logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
   logic [31:0] in_data0, out_data0;
   logic [1:0]  occ0, st0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q1[$];
   logic [31:0] exp_q0[$];
   logic [31:0] model1, model0;
   logic        en1 = 1'b0;
   logic        en0 = 1'b0;
   logic        seen33 = 1'b0;

   pipe_skid_reg #(.WIDTH(32), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .occupancy(occ1), .dbg_state(st1)
   );

   pipe_skid_reg #(.WIDTH(32), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush0),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .occupancy(occ0), .dbg_state(st0)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat on the SKID=1 port and hold it until it is accepted.
   task automatic push1(input logic [31:0] d);
      int n;
      n = 0;
      in_valid1 = 1'b1;
      in_data1  = d;
      #0;
      while (!in_ready1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("push1_timeout", 32'(in_ready1), 32'd1);
      step();
      in_valid1 = 1'b0;
   endtask

   task automatic push0(input logic [31:0] d);
      int n;
      n = 0;
      in_valid0 = 1'b1;
      in_data0  = d;
      #0;
      while (!in_ready0 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("push0_timeout", 32'(in_ready0), 32'd1);
      step();
      in_valid0 = 1'b0;
   endtask

   // Scoreboard for SKID=1: outputs against the queue head, then account the edge.
   always @(negedge clk) begin
      if (en1) begin
         check("occ1", 32'(occ1), 32'(exp_q1.size()));
         check("out_valid1", 32'(out_valid1), 32'(exp_q1.size() != 0));
         check("out_data1", out_data1, model1);
         check("in_ready1", 32'(in_ready1), 32'(exp_q1.size() != 2));
      end
      if (out_valid1 && out_data1 == 32'h33) seen33 = 1'b1;
      if (rst) begin
         exp_q1.delete();
         model1 = '0;
         en1 = 1'b1;
      end else begin
         if (out_valid1 && out_ready1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
         if (flush1) begin
            exp_q1.delete();
            model1 = '0;
         end else begin
            if (in_valid1 && in_ready1) exp_q1.push_back(in_data1);
            if (exp_q1.size() > 0) model1 = exp_q1[0];
         end
      end
   end

   // Scoreboard for SKID=0
   always @(negedge clk) begin
      if (en0) begin
         check("occ0", 32'(occ0), 32'(exp_q0.size()));
         check("out_valid0", 32'(out_valid0), 32'(exp_q0.size() != 0));
         check("out_data0", out_data0, model0);
         check("in_ready0", 32'(in_ready0), 32'((exp_q0.size() == 0) || out_ready0));
      end
      if (rst) begin
         exp_q0.delete();
         model0 = '0;
         en0 = 1'b1;
      end else begin
         if (out_valid0 && out_ready0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
         if (flush0) begin
            exp_q0.delete();
            model0 = '0;
         end else begin
            if (in_valid0 && in_ready0) exp_q0.push_back(in_data0);
            if (exp_q0.size() > 0) model0 = exp_q0[0];
         end
      end
   end

   initial begin
      logic fire1, fire0;
      rst = 1'b1;
      flush1 = 1'b0; in_valid1 = 1'b1; in_data1 = 32'hDEADBEEF; out_ready1 = 1'b0;
      flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = 32'hDEADBEEF; out_ready0 = 1'b0;
      repeat (2) step();

      // Reset / idle: nothing loaded while rst was high
      rst = 1'b0;
      in_valid1 = 1'b0;
      in_valid0 = 1'b0;
      check("rst_out_valid1", 32'(out_valid1), 32'd0);
      check("rst_out_data1", out_data1, 32'd0);
      check("rst_occ1", 32'(occ1), 32'd0);
      check("rst_in_ready1", 32'(in_ready1), 32'd1);
      check("rst_out_valid0", 32'(out_valid0), 32'd0);
      check("rst_out_data0", out_data0, 32'd0);
      check("rst_in_ready0", 32'(in_ready0), 32'd1);
      step();

      // Streaming 1..8 through SKID=1 with out_ready high
      out_ready1 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push1(32'(i));
         check("stream_data", out_data1, 32'(i));
         check("stream_occ", 32'(occ1), 32'd1);
         check("stream_ready", 32'(in_ready1), 32'd1);
      end
      step();
      check("stream_drained", 32'(out_valid1), 32'd0);

      // Backpressure: A, B accepted, C held upstream
      out_ready1 = 1'b0;
      push1(32'hA);
      push1(32'hB);
      check("bp_occ_full", 32'(occ1), 32'd2);
      check("bp_ready_low", 32'(in_ready1), 32'd0);
      in_valid1 = 1'b1;
      in_data1  = 32'hC;
      step();
      step();
      check("bp_hold_occ", 32'(occ1), 32'd2);
      check("bp_hold_data", out_data1, 32'hA);
      out_ready1 = 1'b1;
      push1(32'hC);
      repeat (3) step();
      check("bp_drained", 32'(out_valid1), 32'd0);

      // Flush while FULL, with a concurrent beat that must be discarded
      out_ready1 = 1'b0;
      push1(32'h11);
      push1(32'h22);
      check("fl_full", 32'(occ1), 32'd2);
      in_valid1 = 1'b1;
      in_data1  = 32'h33;
      flush1    = 1'b1;
      step();
      flush1    = 1'b0;
      in_valid1 = 1'b0;
      check("fl_out_valid", 32'(out_valid1), 32'd0);
      check("fl_occ", 32'(occ1), 32'd0);
      check("fl_out_data", out_data1, 32'd0);
      check("fl_in_ready", 32'(in_ready1), 32'd1);
      out_ready1 = 1'b1;
      repeat (3) step();
      check("fl_no_33", 32'(seen33), 32'd0);

      // SKID=0: in_ready follows out_ready within the cycle while holding 0x5
      out_ready0 = 1'b0;
      push0(32'h5);
      check("s0_ready_low", 32'(in_ready0), 32'd0);
      out_ready0 = 1'b1;
      #1;
      check("s0_ready_mirror_hi", 32'(in_ready0), 32'd1);
      out_ready0 = 1'b0;
      #1;
      check("s0_ready_mirror_lo", 32'(in_ready0), 32'd0);
      out_ready0 = 1'b1;
      in_valid0  = 1'b1;
      in_data0   = 32'h6;
      step();
      in_valid0 = 1'b0;
      check("s0_replace_valid", 32'(out_valid0), 32'd1);
      check("s0_replace_data", out_data0, 32'h6);
      check("s0_replace_occ", 32'(occ0), 32'd1);
      step();
      check("s0_drained", 32'(out_valid0), 32'd0);

      // Random traffic on both instances; the scoreboards do the checking
      fire1 = 1'b0;
      fire0 = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         if (!in_valid1 || fire1) begin
            in_valid1 = ($urandom_range(0, 99) < 60);
            in_data1  = $urandom;
         end
         if (!in_valid0 || fire0) begin
            in_valid0 = ($urandom_range(0, 99) < 60);
            in_data0  = $urandom;
         end
         out_ready1 = ($urandom_range(0, 99) < 55);
         out_ready0 = ($urandom_range(0, 99) < 55);
         flush1 = ($urandom_range(0, 99) < 2);
         flush0 = ($urandom_range(0, 99) < 2);
         #1;
         fire1 = in_valid1 & in_ready1;
         fire0 = in_valid0 & in_ready0;
         step();
      end
      in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1;
      in_valid0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b1;
      repeat (4) step();
      check("end_empty1", 32'(exp_q1.size()), 32'd0);
      check("end_empty0", 32'(exp_q0.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
